// File: rtl/store_tank_if.sv
// -----------------------------------------------------------------------------
// store_tank_if
//   Bus between the transfer unit and a serial store tank.
//
//   Handshake: req is a one-cycle request that the tank samples only while
//   idle, together with wr and addr. After acceptance, busy stays high until
//   the transfer completes. done pulses for exactly one cycle at completion,
//   and a new req may be presented in that same done cycle. A req seen while
//   busy is dropped.
//
//   Signals (direction seen from the tank / slave side):
//     req     in   transfer request, sampled only while idle
//     wr      in   1 = write mob into the word, 0 = read the word onto mib
//     addr    in   target word (minor-cycle) index
//     mob     in   serial write data, LSB first
//     mib     out  serial read data, LSB first, registered
//     busy    out  transfer in progress
//     done    out  one-cycle completion pulse
//     pi_cnt  out  pulse interval within the current minor cycle
//     mc_cnt  out  minor cycle, i.e. the index of the word at the tank tail
//     mon_bit / mon_sync  out  monitor-tube taps (only with TANK_MONITOR_EN)
// -----------------------------------------------------------------------------
interface store_tank_if #(
  parameter int WORDS     = 16,
  parameter int WORD_BITS = 36
) ();
  localparam int AW = $clog2(WORDS);
  localparam int PW = $clog2(WORD_BITS);

  logic          req;
  logic          wr;
  logic [AW-1:0] addr;
  logic          mob;
  logic          mib;
  logic          busy;
  logic          done;
  logic [PW-1:0] pi_cnt;
  logic [AW-1:0] mc_cnt;
`ifdef TANK_MONITOR_EN
  logic          mon_bit;
  logic          mon_sync;
`endif

  // Transfer-unit side.
  modport master (
    output req, wr, addr, mob,
    input  mib, busy, done, pi_cnt, mc_cnt
`ifdef TANK_MONITOR_EN
    , input mon_bit, mon_sync
`endif
  );

  // Tank side.
  modport slave (
    input  req, wr, addr, mob,
    output mib, busy, done, pi_cnt, mc_cnt
`ifdef TANK_MONITOR_EN
    , output mon_bit, mon_sync
`endif
  );
endinterface

// File: rtl/store_tank.sv
// -----------------------------------------------------------------------------
// store_tank
//   Serial mercury-delay-line store tank. The tank holds WORDS words of
//   WORD_BITS pulse intervals each. The words recirculate continuously and
//   travel bit-serially, LSB first, one bit per clk.
//
//   Ports:
//     clk      pulse-interval clock
//     rst      asynchronous, active-high reset. It clears the storage and the
//              counters, and it aborts any transfer without a done pulse.
//     bus      store_tank_if.slave (req/wr/addr/mob in; mib/busy/done/
//              pi_cnt/mc_cnt out)
//     state_o  current FSM state, exported for observation
//
//   Optional feature (macro TANK_MONITOR_EN): adds the monitor-tube taps
//   bus.mon_bit and bus.mon_sync. Both are registered and both reset to 0.
//
//   The tail is tank_q[0] and the head is tank_q[N-1]. When pi_cnt = p and
//   mc_cnt = m, the tail holds bit p of word m.
// -----------------------------------------------------------------------------
module store_tank #(
  parameter int WORDS     = 16,
  parameter int WORD_BITS = 36
) (
  input  logic        clk,
  input  logic        rst,
  store_tank_if.slave bus,
  output logic [1:0]  state_o
);
  localparam int AW = $clog2(WORDS);
  localparam int PW = $clog2(WORD_BITS);
  localparam int N  = WORDS * WORD_BITS;

  localparam logic [PW-1:0] PI_LAST = PW'(WORD_BITS - 1);
  localparam logic [AW-1:0] MC_LAST = AW'(WORDS - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_XFER = 2'd2
  } state_t;

  state_t        state_q;
  logic [N-1:0]  tank_q,  tank_d;
  logic [PW-1:0] pi_q,    pi_d;
  logic [AW-1:0] mc_q,    mc_d;
  logic [AW-1:0] addr_q;
  logic          wr_q;
  logic          mib_q;
  logic          busy_q;
  logic          done_q;

  logic tail;
  logic pi_last;
  logic word_hit;
  logic gate;

  assign tail     = tank_q[0];
  assign pi_last  = (pi_q == PI_LAST);
  // The selected word is arriving at the tail, starting with its bit 0.
  assign word_hit = (pi_q == '0) && (mc_q == addr_q);
  // The gate opens in the WAIT cycle that sees the word start, which is
  // bit 0 of the transfer. It then stays open through XFER for bits 1..last.
  assign gate     = ((state_q == S_WAIT) && word_hit) || (state_q == S_XFER);

  always_comb begin
    tank_d = {tail, tank_q[N-1:1]};
    if (gate && wr_q) begin
      tank_d[N-1] = bus.mob;
    end
    pi_d = pi_last ? '0 : pi_q + 1'b1;
    mc_d = mc_q;
    if (pi_last) begin
      mc_d = (mc_q == MC_LAST) ? '0 : mc_q + 1'b1;
    end
  end

  // Recirculating delay line and its p.i. / minor-cycle position counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tank_q <= '0;
      pi_q   <= '0;
      mc_q   <= '0;
    end else begin
      tank_q <= tank_d;
      pi_q   <= pi_d;
      mc_q   <= mc_d;
    end
  end

  // Transfer FSM, with registered mib/busy/done outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      wr_q    <= 1'b0;
      mib_q   <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      // A read copies the tail out without disturbing recirculation.
      mib_q  <= (gate && !wr_q) ? tail : 1'b0;
      case (state_q)
        S_IDLE: begin
          if (bus.req) begin
            addr_q  <= bus.addr;
            wr_q    <= bus.wr;
            busy_q  <= 1'b1;
            state_q <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (word_hit) begin
            state_q <= S_XFER;
          end
        end
        S_XFER: begin
          if (pi_last) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_IDLE;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.mib    = mib_q;
  assign bus.busy   = busy_q;
  assign bus.done   = done_q;
  assign bus.pi_cnt = pi_q;
  assign bus.mc_cnt = mc_q;
  assign state_o    = state_q;

`ifdef TANK_MONITOR_EN
  logic mon_bit_q;
  logic mon_sync_q;

  // The monitor tube shows the raw tail regardless of gating. The sync mark
  // flags the start of word 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mon_bit_q  <= 1'b0;
      mon_sync_q <= 1'b0;
    end else begin
      mon_bit_q  <= tail;
      mon_sync_q <= (pi_q == '0) && (mc_q == '0);
    end
  end

  assign bus.mon_bit  = mon_bit_q;
  assign bus.mon_sync = mon_sync_q;
`endif
endmodule

// File: tb/tb_store_tank.sv
// -----------------------------------------------------------------------------
// tb_store_tank
//   Directed bench for store_tank. It keeps its own cycle count since reset,
//   from which it derives the expected pi_cnt/mc_cnt and the expected gate
//   time of every transfer.
// -----------------------------------------------------------------------------
module tb_store_tank;
  localparam int WORDS     = 16;
  localparam int WORD_BITS = 36;
  localparam int MAJOR     = WORDS * WORD_BITS;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:0] state;

  store_tank_if #(.WORDS(WORDS), .WORD_BITS(WORD_BITS)) tank_if ();

  store_tank #(.WORDS(WORDS), .WORD_BITS(WORD_BITS)) u_dut (
    .clk     (clk),
    .rst     (rst),
    .bus     (tank_if.slave),
    .state_o (state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  // Cycles elapsed since reset release.
  int cyc;
  always @(posedge clk or posedge rst) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Advance to the cycle with the given position. The wait is bounded by one
  // major cycle.
  task automatic wait_to(input int p, input int m);
    int n;
    n = 0;
    while (!(((cyc % WORD_BITS) == p) && (((cyc / WORD_BITS) % WORDS) == m)) && n < MAJOR) begin
      step();
      n++;
    end
    check_eq("wait_pi", 64'(tank_if.pi_cnt), 64'(p));
    check_eq("wait_mc", 64'(tank_if.mc_cnt), 64'(m));
  endtask

  // Issue one transfer in the current cycle and follow it to its done cycle.
  //   inj_off   >= 0: pulse a read req to inj_addr at gate + inj_off
  //   abort_bit >= 0: assert rst during that bit of the gated window
  task automatic xfer(input logic w, input int a, input logic [35:0] data,
                      input int inj_off, input int inj_addr, input int abort_bit,
                      output logic [35:0] rdata, output int done_at);
    int   k;
    int   pos0;
    int   busy_bad;
    int   mib_bad;
    int   cnt_bad;
    int   done_cnt;
    logic aborted;
    pos0     = cyc % MAJOR;
    k        = (a * WORD_BITS - pos0 + MAJOR) % MAJOR;
    if (k == 0) k = MAJOR;
    rdata    = '0;
    done_at  = -1;
    busy_bad = 0;
    mib_bad  = 0;
    cnt_bad  = 0;
    done_cnt = 0;
    aborted  = 1'b0;
    tank_if.req  = 1'b1;
    tank_if.wr   = w;
    tank_if.addr = 4'(a);
    tank_if.mob  = 1'($urandom_range(0, 1));
    for (int i = 1; i <= k + WORD_BITS; i++) begin
      step();
      tank_if.req = (inj_off >= 0) && (i == k + inj_off);
      if (tank_if.req) begin
        tank_if.wr   = 1'b0;
        tank_if.addr = 4'(inj_addr);
      end
      if ((32'(tank_if.pi_cnt) != cyc % WORD_BITS) ||
          (32'(tank_if.mc_cnt) != (cyc / WORD_BITS) % WORDS)) cnt_bad++;
      if (tank_if.busy !== (i <= k + WORD_BITS - 1)) busy_bad++;
      if (tank_if.done === 1'b1) begin
        done_cnt++;
        done_at = i;
      end
      if (i > k) rdata[i-k-1] = tank_if.mib;
      else if (tank_if.mib !== 1'b0) mib_bad++;
      if (w && i >= k && i <= k + WORD_BITS - 1) tank_if.mob = data[i-k];
      else tank_if.mob = 1'($urandom_range(0, 1));
      if (abort_bit >= 0 && i == k + abort_bit) begin
        rst = 1'b1;
        #1;
        check_eq("abort_mib",   64'(tank_if.mib),    64'd0);
        check_eq("abort_busy",  64'(tank_if.busy),   64'd0);
        check_eq("abort_done",  64'(tank_if.done),   64'd0);
        check_eq("abort_pi",    64'(tank_if.pi_cnt), 64'd0);
        check_eq("abort_mc",    64'(tank_if.mc_cnt), 64'd0);
        check_eq("abort_state", 64'(state),          64'd0);
        tank_if.req = 1'b0;
        rst = 1'b0;
        aborted = 1'b1;
        break;
      end
    end
    tank_if.req = 1'b0;
    check_eq("cnt_track",   64'(cnt_bad),  64'd0);
    check_eq("busy_window", 64'(busy_bad), 64'd0);
    check_eq("mib_idle",    64'(mib_bad),  64'd0);
    if (w) check_eq("mib_quiet_on_write", 64'(rdata), 64'd0);
    if (aborted) begin
      check_eq("abort_no_done", 64'(done_cnt), 64'd0);
    end else begin
      check_eq("done_count", 64'(done_cnt), 64'd1);
      check_eq("done_at",    64'(done_at),  64'(k + WORD_BITS));
    end
  endtask

  // ---------------- main sequence ----------------
  logic [35:0] rd;
  int          dat;

  initial begin
    rst          = 1'b1;
    tank_if.req  = 1'b0;
    tank_if.wr   = 1'b0;
    tank_if.addr = '0;
    tank_if.mob  = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_eq("rst_mib",   64'(tank_if.mib),    64'd0);
    check_eq("rst_busy",  64'(tank_if.busy),   64'd0);
    check_eq("rst_done",  64'(tank_if.done),   64'd0);
    check_eq("rst_pi",    64'(tank_if.pi_cnt), 64'd0);
    check_eq("rst_mc",    64'(tank_if.mc_cnt), 64'd0);
    check_eq("rst_state", 64'(state),          64'd0);

    // Fresh tank reads zero.
    xfer(1'b0, 9, '0, -1, 0, -1, rd, dat);
    check_eq("rd9_fresh", 64'(rd), 64'd0);

    // Write word 5, read it back, and confirm its neighbours are untouched.
    // Each transfer starts in the done cycle of the previous one.
    xfer(1'b1, 5, 36'h8_0000_0001, -1, 0, -1, rd, dat);
    xfer(1'b0, 5, '0, -1, 0, -1, rd, dat);
    check_eq("rd5", 64'(rd), 64'h8_0000_0001);
    xfer(1'b0, 4, '0, -1, 0, -1, rd, dat);
    check_eq("rd4_zero", 64'(rd), 64'd0);
    xfer(1'b0, 6, '0, -1, 0, -1, rd, dat);
    check_eq("rd6_zero", 64'(rd), 64'd0);

    // Last word plus wrap of the counters.
    xfer(1'b1, 15, 36'hF_FFFF_FFFF, -1, 0, -1, rd, dat);
    xfer(1'b0, 0, '0, -1, 0, -1, rd, dat);
    check_eq("rd0_zero", 64'(rd), 64'd0);
    xfer(1'b0, 15, '0, -1, 0, -1, rd, dat);
    check_eq("rd15_ones", 64'(rd), 64'hF_FFFF_FFFF);
    wait_to(35, 15);
    step();
    check_eq("wrap_pi", 64'(tank_if.pi_cnt), 64'd0);
    check_eq("wrap_mc", 64'(tank_if.mc_cnt), 64'd0);

    // A req accepted exactly at the start of its word waits a full major
    // cycle: 576 cycles to the gate plus 36 cycles to done.
    wait_to(0, 3);
    xfer(1'b0, 3, '0, -1, 0, -1, rd, dat);
    check_eq("latency_done_at", 64'(dat), 64'd612);
    check_eq("rd3_zero", 64'(rd), 64'd0);

    // A read req pulsed mid-write is ignored.
    xfer(1'b1, 2, 36'h1_2345_6789, 5, 9, -1, rd, dat);
    xfer(1'b0, 2, '0, -1, 0, -1, rd, dat);
    check_eq("rd2_inj", 64'(rd), 64'h1_2345_6789);
    xfer(1'b0, 9, '0, -1, 0, -1, rd, dat);
    check_eq("rd9_inj_zero", 64'(rd), 64'd0);
    xfer(1'b0, 5, '0, -1, 0, -1, rd, dat);
    check_eq("rd5_kept", 64'(rd), 64'h8_0000_0001);

    // Reset at bit 10 of a write to word 7 clears everything.
    xfer(1'b1, 7, 36'hA_5A5A_5A5A, -1, 0, 10, rd, dat);
    xfer(1'b0, 7, '0, -1, 0, -1, rd, dat);
    check_eq("rd7_after_abort", 64'(rd), 64'd0);
    xfer(1'b0, 5, '0, -1, 0, -1, rd, dat);
    check_eq("rd5_after_abort", 64'(rd), 64'd0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end
endmodule
